rbus_pkt_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one rbus output channel between N requesters. It sits in front of the N-to-1 reduction mux: it drives the one-hot grant and the select index that steer that mux. It holds each grant for exactly one whole packet, and it monitors the granted requester's strobe and start-of-frame stream for protocol violations. A sticky error flag and a watchdog abort protect the shared channel from a stalled or misbehaving source.

---
 rtl/rbus_pkt_arbiter_if.sv | 21 ++
 rtl/rbus_pkt_arbiter.sv | 114 +++++++++++
 tb/tb_rbus_pkt_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rbus_pkt_arbiter_if.sv
// rbus_pkt_arbiter_if: request/monitor inputs and grant outputs of the packet arbiter
interface rbus_pkt_arbiter_if #(
  parameter int N  = 4,
  parameter int LW = 5
);
  localparam int SW = $clog2(N);
  logic [N-1:0]  i_req;
  logic [LW-1:0] i_len [0:N-1];
  logic          i_stb [0:N-1];
  logic          i_sof [0:N-1];
  logic          i_dst_rdy;
  logic [N-1:0]  o_gnt;
  logic [SW-1:0] o_sel;
  logic          o_busy;
  logic          o_abort;
  logic          ff_err;
  modport master (output i_req, i_len, i_stb, i_sof, i_dst_rdy,
                  input  o_gnt, o_sel, o_busy, o_abort, ff_err);
  modport slave  (input  i_req, i_len, i_stb, i_sof, i_dst_rdy,
                  output o_gnt, o_sel, o_busy, o_abort, ff_err);
endinterface

// File: rtl/rbus_pkt_arbiter.sv
// rbus_pkt_arbiter: packet-granular round-robin arbiter with protocol monitor and watchdog
module rbus_pkt_arbiter #(
  parameter int N  = 4,
  parameter int LW = 5,
  parameter int TO = 64
) (
  input logic               clk,
  input logic               rst,
  rbus_pkt_arbiter_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int WW = $clog2(TO + 1);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [SW-1:0] sel_q, sel_d, ptr_q, ptr_d, win;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          first_q, first_d, abort_q, abort_d, err_q, err_d;
  logic          found, rogue, word, exit_b;
  // Scan downward so the candidate closest to ptr is written last and wins.
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.i_req[(int'(ptr_q) + i) % N]) begin
        win = SW'((int'(ptr_q) + i) % N);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    rogue = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (bus.i_stb[j] && !gnt_q[j]) rogue = 1'b1;
    end
  end
  assign word = (state_q == BUSY) && bus.i_stb[sel_q];
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    first_d = first_q;
    abort_d = 1'b0;
    err_d   = err_q | rogue;
    exit_b  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_dst_rdy && found) begin
        state_d = BUSY;
        gnt_d   = N'(1) << win;
        sel_d   = win;
        cnt_d   = bus.i_len[win];
        wd_d    = '0;
        first_d = 1'b1;
        if (bus.i_len[win] == '0) err_d = 1'b1;
      end
      BUSY: begin
        if (cnt_q == '0) exit_b = 1'b1;
        else if (word) begin
          first_d = 1'b0;
          cnt_d   = cnt_q - 1'b1;
          wd_d    = '0;
          if (first_q != bus.i_sof[sel_q]) err_d = 1'b1;
          if (cnt_q == LW'(1)) exit_b = 1'b1;
        end else begin
          wd_d = (wd_q == WW'(TO)) ? wd_q : wd_q + 1'b1;
          if (wd_q == WW'(TO - 1)) begin
            exit_b  = 1'b1;
            abort_d = 1'b1;
            err_d   = 1'b1;
          end
        end
        if (exit_b) begin
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = (sel_q == SW'(N - 1)) ? '0 : sel_q + 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      first_q <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      first_q <= first_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end
  assign bus.o_gnt   = gnt_q;
  assign bus.o_sel   = sel_q;
  assign bus.o_busy  = (state_q == BUSY);
  assign bus.o_abort = abort_q;
  assign bus.ff_err  = err_q;
endmodule

// File: tb/tb_rbus_pkt_arbiter.sv
// tb_rbus_pkt_arbiter: randomized packet traffic against a transaction-level arbiter model
module tb_rbus_pkt_arbiter;
  localparam int N = 4, LW = 5, TO = 8;
  typedef struct {int c; int v;} ev_t;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0, cyc = 0;
  ev_t gq[$], eq[$], mg;
  int errq[$];
  int ptr_m = 0, ci = 0;
  bit err_m = 1'b0;
  logic [LW-1:0] lens [0:N-1];
  logic [N-1:0] pg;
  logic pe;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  rbus_pkt_arbiter_if #(.N(N), .LW(LW)) bus ();
  rbus_pkt_arbiter #(.N(N), .LW(LW), .TO(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  function automatic void note_err(int e);
    if (!err_m) begin
      err_m = 1'b1;
      errq.push_back(e);
    end
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in;
    bus.i_req = '0;
    bus.i_dst_rdy = 1'b0;
    for (int j = 0; j < N; j++) begin
      bus.i_stb[j] = 1'b0;
      bus.i_sof[j] = 1'b0;
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    #1;
    chk("rst_gnt", bus.o_gnt, 0);
    chk("rst_sel", bus.o_sel, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_abort", bus.o_abort, 0);
    chk("rst_err", bus.ff_err, 0);
    clear_in;
    tick;
    rst = 1'b0;
    ptr_m = 0;
    err_m = 1'b0;
    gq.delete();
    eq.delete();
    errq.delete();
  endtask
  task automatic seg_end;
    tick;
    chk("pending_grants", gq.size(), 0);
    chk("pending_ends", eq.size(), 0);
    chk("pending_errs", errq.size(), 0);
    chk("err_final", bus.ff_err, err_m);
    do_reset;
  endtask
  // One arbitration plus the granted packet; the model only counts words and idle runs.
  task automatic run_packet(input logic [N-1:0] mask, input int d, input bit rnd,
                            input int stall, input int kill_at);
    int w, cnt, wd, nw, oth;
    bit first, done, word, sof, ab;
    ev_t t;
    w = 0;
    for (int i = N - 1; i >= 0; i--) if (mask[(ptr_m + i) % N]) w = (ptr_m + i) % N;
    bus.i_req = mask;
    for (int j = 0; j < N; j++) bus.i_len[j] = lens[j];
    bus.i_dst_rdy = 1'b0;
    repeat (d) tick;
    bus.i_dst_rdy = 1'b1;
    tick;
    t.c = cyc; t.v = w;
    gq.push_back(t);
    bus.i_dst_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.i_req = rnd ? N'($urandom) : '0;
    cnt = int'(lens[w]); wd = 0; nw = 0; first = 1'b1; done = 1'b0; ab = 1'b0;
    if (cnt == 0) begin
      note_err(cyc);
      tick;
      done = 1'b1;
    end
    while (!done) begin
      word = (stall >= 0 && nw >= stall) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      sof = first ? (!rnd || $urandom_range(0, 9) != 0) : (rnd && $urandom_range(0, 14) == 0);
      oth = (rnd && $urandom_range(0, 24) == 0) ? (w + 1 + int'($urandom_range(0, N - 2))) % N : -1;
      for (int j = 0; j < N; j++) begin
        bus.i_stb[j] = (j == w && word) || j == oth;
        bus.i_sof[j] = (j == w) && sof;
      end
      if (kill_at > 0 && word && nw + 1 == kill_at) begin
        #2;
        do_reset;
        return;
      end
      tick;
      if (oth >= 0) note_err(cyc);
      if (word) begin
        if (first != sof) note_err(cyc);
        first = 1'b0;
        cnt--;
        wd = 0;
        nw++;
        if (cnt == 0) done = 1'b1;
      end else begin
        wd++;
        if (wd == TO) begin
          done = 1'b1;
          ab = 1'b1;
          note_err(cyc);
        end
      end
    end
    t.c = cyc; t.v = int'(ab);
    eq.push_back(t);
    ptr_m = (w + 1) % N;
    clear_in;
    tick;
  endtask
  initial begin
    pg = '0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pg = '0;
        pe = 1'b0;
      end else begin
        if (bus.o_gnt != '0 && pg == '0) begin
          if (gq.size() == 0) chk("unexpected_grant", bus.o_gnt, 0);
          else begin
            mg = gq.pop_front();
            chk("grant_cycle", cyc, mg.c);
            chk("grant_onehot", bus.o_gnt, 1 << mg.v);
            chk("grant_sel", bus.o_sel, mg.v);
            chk("grant_busy", bus.o_busy, 1);
            ci = mg.v;
          end
        end
        if (bus.o_gnt == '0 && pg != '0) begin
          if (eq.size() == 0) chk("unexpected_end", 1, 0);
          else begin
            mg = eq.pop_front();
            chk("end_cycle", cyc, mg.c);
            chk("end_abort", bus.o_abort, mg.v);
            chk("end_busy", bus.o_busy, 0);
            chk("end_sel_hold", bus.o_sel, ci);
          end
        end else if (bus.o_abort) chk("stray_abort", 1, 0);
        if (bus.ff_err && !pe) begin
          if (errq.size() == 0) chk("unexpected_err", 1, 0);
          else chk("err_cycle", cyc, errq.pop_front());
        end
        pg = bus.o_gnt;
        pe = bus.ff_err;
      end
    end
  end
  initial begin
    clear_in;
    for (int j = 0; j < N; j++) lens[j] = LW'(3);
    repeat (2) tick;
    do_reset;
    run_packet(4'b0100, 0, 1'b0, -1, 0);
    seg_end;
    for (int j = 0; j < N; j++) lens[j] = LW'(1);
    repeat (5) run_packet(4'b1111, 0, 1'b0, -1, 0);
    seg_end;
    lens[1] = LW'(2);
    run_packet(4'b0010, 10, 1'b0, -1, 0);
    lens[1] = LW'(4);
    run_packet(4'b0010, 0, 1'b0, 1, 0);
    run_packet(4'b1111, 0, 1'b0, -1, 0);
    seg_end;
    for (int j = 0; j < N; j++) lens[j] = LW'(5);
    run_packet(4'b0010, 0, 1'b0, -1, 2);
    run_packet(4'b1111, 0, 1'b0, -1, 0);
    seg_end;
    repeat (40) begin
      repeat ($urandom_range(1, 6)) begin
        for (int j = 0; j < N; j++)
          lens[j] = ($urandom_range(0, 15) == 0) ? '0 : LW'($urandom_range(1, 6));
        run_packet(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 4), 1'b1,
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1, 0);
      end
      seg_end;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
